// File: rtl/ooop_types_pkg.sv
// Shared out-of-order pipeline types: ROB tag space and branch checkpoint records.
`default_nettype none

package ooop_types;

    localparam int ROB_DEPTH  = 32;
    localparam int ROB_W      = $clog2(ROB_DEPTH);
    localparam int DEF_MAX_BR = 4;
    localparam int BR_W       = $clog2(DEF_MAX_BR);

    typedef enum logic [1:0] {
        CK_IDLE    = 2'd0,
        CK_RECOVER = 2'd1,
        CK_DRAIN   = 2'd2
    } ckpt_state_e;

    typedef struct packed {
        logic             valid;
        logic             resolved;
        logic [ROB_W-1:0] tag;
    } ckpt_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_ckpt_ctrl_queue.sv
// In-order checkpoint queue: tail push, resolve CAM, head pop and mispredict truncation.
`default_nettype none

module ckpt_queue
    import ooop_types::*;
#(
    parameter int  MAX_BR = 4,
    parameter int  TAG_W  = ooop_types::ROB_W,
    localparam int QB_W   = $clog2(MAX_BR),
    localparam int CNT_W  = $clog2(MAX_BR + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_mispredict,
    output logic             mp_accept,
    output logic [CNT_W-1:0] count
);

    ckpt_entry_t            entries [MAX_BR];
    logic [QB_W-1:0]        head;
    logic [QB_W-1:0]        tail;
    logic                   hit;
    logic [QB_W-1:0]        hit_idx;
    logic [QB_W-1:0]        hit_off;
    logic [QB_W-1:0]        off;
    logic [MAX_BR-1:0]      squash;
    logic                   pop;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        squash  = '0;
        off     = '0;
        for (int i = 0; i < MAX_BR; i++) begin
            if (!hit && entries[i].valid && entries[i].tag == resolve_tag) begin
                hit     = 1'b1;
                hit_idx = QB_W'(i);
            end
        end
        hit_off = hit_idx - head;
        // Age is the distance from head; anything farther than the hit is younger.
        for (int i = 0; i < MAX_BR; i++) begin
            off       = QB_W'(i) - head;
            squash[i] = off > hit_off;
        end
        pop       = entries[head].valid & entries[head].resolved;
        mp_accept = resolve_valid & resolve_mispredict & hit & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < MAX_BR; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (resolve_valid && hit) begin
                entries[hit_idx].resolved <= 1'b1;
            end
            if (mp_accept) begin
                for (int i = 0; i < MAX_BR; i++) begin
                    if (squash[i]) begin
                        entries[i].valid <= 1'b0;
                    end
                end
                tail  <= hit_idx + 1'b1;
                count <= CNT_W'(hit_off) + 1'b1 - CNT_W'(pop);
            end else begin
                if (push) begin
                    entries[tail] <= '{valid: 1'b1, resolved: 1'b0, tag: push_tag};
                    tail          <= tail + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller: slot grant/stall, mispredict recovery FSM and drain window.
// Optional OOOP_CKPT_PERF_EN adds saturating mispredict and stall-cycle counters.
`default_nettype none

module branch_ckpt_ctrl
    import ooop_types::*;
#(
    parameter int  ROB_DEPTH    = ooop_types::ROB_DEPTH,
    parameter int  MAX_BR       = 4,
    parameter int  DRAIN_CYCLES = 2,
    localparam int TAG_W        = $clog2(ROB_DEPTH),
    localparam int CNT_W        = $clog2(MAX_BR + 1),
    localparam int DR_W         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             br_rename_valid_i,
    input  logic [TAG_W-1:0] br_rename_tag_i,
    output logic             br_stall_o,
    output logic             ckpt_take_o,
    output logic [TAG_W-1:0] ckpt_tag_o,
    input  logic             resolve_valid_i,
    input  logic [TAG_W-1:0] resolve_tag_i,
    input  logic             resolve_mispredict_i,
    output logic             recover_o,
    output logic [TAG_W-1:0] recover_tag_o,
    output logic             rename_block_o,
`ifdef OOOP_CKPT_PERF_EN
    output logic [31:0]      perf_mispredict_o,
    output logic [31:0]      perf_stall_o,
`endif
    output logic [CNT_W-1:0] outstanding_o
);

    ckpt_state_e       state;
    ckpt_state_e       state_next;
    logic [DR_W-1:0]   drain_cnt;
    logic [DR_W-1:0]   drain_cnt_next;
    logic              mp_accept;

    ckpt_queue #(
        .MAX_BR (MAX_BR),
        .TAG_W  (TAG_W)
    ) u_queue (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush_i),
        .push               (ckpt_take_o),
        .push_tag           (br_rename_tag_i),
        .resolve_valid      (resolve_valid_i),
        .resolve_tag        (resolve_tag_i),
        .resolve_mispredict (resolve_mispredict_i),
        .mp_accept          (mp_accept),
        .count              (outstanding_o)
    );

    assign br_stall_o     = (outstanding_o == CNT_W'(MAX_BR));
    assign rename_block_o = (state != CK_IDLE);
    assign recover_o      = (state == CK_RECOVER);
    // A branch renaming alongside a mispredict is younger and loses its tag on recovery.
    assign ckpt_take_o    = br_rename_valid_i & ~br_stall_o & ~rename_block_o & ~mp_accept;
    assign ckpt_tag_o     = br_rename_tag_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CK_IDLE;
            drain_cnt     <= '0;
            recover_tag_o <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            if (mp_accept) begin
                recover_tag_o <= resolve_tag_i;
            end
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (flush_i) begin
            state_next     = CK_IDLE;
            drain_cnt_next = '0;
        end else if (mp_accept) begin
            state_next = CK_RECOVER;
        end else begin
            case (state)
                CK_RECOVER: begin
                    state_next     = CK_DRAIN;
                    drain_cnt_next = DR_W'(DRAIN_CYCLES - 1);
                end
                CK_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_next = CK_IDLE;
                    end else begin
                        drain_cnt_next = drain_cnt - 1'b1;
                    end
                end
                default: state_next = CK_IDLE;
            endcase
        end
    end

`ifdef OOOP_CKPT_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_mispredict_o <= '0;
            perf_stall_o      <= '0;
        end else begin
            if (mp_accept && perf_mispredict_o != '1) begin
                perf_mispredict_o <= perf_mispredict_o + 32'd1;
            end
            if (br_rename_valid_i && br_stall_o && perf_stall_o != '1) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_ckpt_ctrl.sv
// Testbench for branch_ckpt_ctrl: directed scenarios plus randomized traffic against a queue model.
`default_nettype none

module tb_branch_ckpt_ctrl;

    localparam int MAX_BR = 4;
    localparam int DC     = 2;
    localparam int RW     = 5;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          br_valid = 1'b0;
    logic [RW-1:0] br_tag = '0;
    logic          rs_valid = 1'b0;
    logic [RW-1:0] rs_tag = '0;
    logic          rs_mp = 1'b0;
    logic          stall, take, recover, block;
    logic [RW-1:0] ck_tag, rec_tag;
    logic [CW-1:0] outstanding;
`ifdef OOOP_CKPT_PERF_EN
    logic [31:0]   perf_mp, perf_st;
`endif

    branch_ckpt_ctrl #(
        .MAX_BR       (MAX_BR),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .flush_i              (flush),
        .br_rename_valid_i    (br_valid),
        .br_rename_tag_i      (br_tag),
        .br_stall_o           (stall),
        .ckpt_take_o          (take),
        .ckpt_tag_o           (ck_tag),
        .resolve_valid_i      (rs_valid),
        .resolve_tag_i        (rs_tag),
        .resolve_mispredict_i (rs_mp),
        .recover_o            (recover),
        .recover_tag_o        (rec_tag),
        .rename_block_o       (block),
`ifdef OOOP_CKPT_PERF_EN
        .perf_mispredict_o    (perf_mp),
        .perf_stall_o         (perf_st),
`endif
        .outstanding_o        (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        bit res;
    } ent_t;

    ent_t mq[$];       // live checkpoints, oldest first
    bit   m_rec;
    int   m_block;     // cycles of rename block still expected
    int   m_rtag;
    int   errors = 0;
    int   checks = 0;

    function automatic int find(int t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic bit m_mp();
        return rs_valid && rs_mp && !flush && find(int'(rs_tag)) >= 0;
    endfunction

    function automatic bit m_take();
        return br_valid && mq.size() < MAX_BR && m_block == 0 && !m_mp();
    endfunction

    task automatic tick();
        bit pop, mp, tk;
        int idx;
        if (!rst_n) begin
            mq.delete(); m_rec = 0; m_block = 0; m_rtag = 0;
        end else if (flush) begin
            mq.delete(); m_rec = 0; m_block = 0;
        end else begin
            pop = mq.size() > 0 && mq[0].res;
            idx = find(int'(rs_tag));
            mp  = m_mp();
            tk  = m_take();
            if (rs_valid && idx >= 0) mq[idx].res = 1;
            if (mp) begin
                while (mq.size() > idx + 1) void'(mq.pop_back());
            end else if (tk) begin
                mq.push_back('{int'(br_tag), 1'b0});
            end
            if (pop) void'(mq.pop_front());
            if (mp) begin
                m_rec = 1; m_block = DC + 1; m_rtag = int'(rs_tag);
            end else begin
                m_rec = 0;
                if (m_block > 0) m_block--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; br_valid = 0; rs_valid = 0; rs_mp = 0;
    endtask

    task automatic push_tag(int t);
        idle();
        br_valid = 1; br_tag = RW'(t);
        #1;
        checks++;
        if (take !== 1'b1 || ck_tag !== RW'(t)) begin
            errors++;
            $display("FAIL push_take tag=%0d: take=%b ck_tag=%0d, want take=1 ck_tag=%0d", t, take, ck_tag, t);
        end
        tick();
        idle();
    endtask

    task automatic resolve(int t, bit mp);
        idle();
        rs_valid = 1; rs_tag = RW'(t); rs_mp = mp;
        tick();
        idle();
    endtask

    task automatic do_flush();
        idle();
        flush = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick();
        tick();
        checks++;
        if ({outstanding, stall, recover, block, rec_tag} !== '0) begin
            errors++;
            $display("FAIL reset: outst=%0d stall=%b rec=%b blk=%b rtag=%0d, want all 0",
                     outstanding, stall, recover, block, rec_tag);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_fill_stall();
        push_tag(3); push_tag(5); push_tag(7); push_tag(9);
        checks++;
        if (outstanding !== 3'd4 || stall !== 1'b1) begin
            errors++;
            $display("FAIL fill: outst=%0d stall=%b, want 4 1", outstanding, stall);
        end
        br_valid = 1; br_tag = 5'd11;
        #1;
        checks++;
        if (take !== 1'b0) begin
            errors++;
            $display("FAIL stall_take: take=%b, want 0", take);
        end
        tick();
        idle();
    endtask

    task automatic test_retire();
        resolve(5, 0);
        resolve(3, 0);
        tick();
        tick();
        checks++;
        if (outstanding !== 3'd2 || stall !== 1'b0) begin
            errors++;
            $display("FAIL retire: outst=%0d stall=%b, want 2 0", outstanding, stall);
        end
    endtask

    task automatic test_mispredict();
        do_flush();
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL flush_empty: outst=%0d, want 0", outstanding);
        end
        push_tag(3); push_tag(5); push_tag(7); push_tag(9);
        resolve(5, 1);
        checks++;
        if (recover !== 1'b1 || rec_tag !== 5'd5 || block !== 1'b1 || outstanding !== 3'd2) begin
            errors++;
            $display("FAIL mp_T1: rec=%b rtag=%0d blk=%b outst=%0d, want 1 5 1 2",
                     recover, rec_tag, block, outstanding);
        end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if (recover !== 1'b0 || block !== (k <= 3)) begin
                errors++;
                $display("FAIL mp_block T+%0d: rec=%b blk=%b, want 0 %b", k, recover, block, k <= 3);
            end
        end
        resolve(3, 0);
        tick();
        tick();
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL mp_drain_queue: outst=%0d, want 0", outstanding);
        end
    endtask

    task automatic test_race();
        do_flush();
        push_tag(3); push_tag(5);
        br_valid = 1; br_tag = 5'd12;
        rs_valid = 1; rs_tag = 5'd5; rs_mp = 1;
        #1;
        checks++;
        if (take !== 1'b0) begin
            errors++;
            $display("FAIL race_take: take=%b, want 0", take);
        end
        tick();
        idle();
        checks++;
        if (outstanding !== 3'd2 || recover !== 1'b1) begin
            errors++;
            $display("FAIL race_queue: outst=%0d rec=%b, want 2 1", outstanding, recover);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_nested();
        do_flush();
        push_tag(3); push_tag(5); push_tag(7); push_tag(9);
        resolve(7, 1);
        checks++;
        if (recover !== 1'b1 || rec_tag !== 5'd7) begin
            errors++;
            $display("FAIL nest_first: rec=%b rtag=%0d, want 1 7", recover, rec_tag);
        end
        tick();
        resolve(3, 1);
        checks++;
        if (recover !== 1'b1 || rec_tag !== 5'd3 || block !== 1'b1) begin
            errors++;
            $display("FAIL nest_second: rec=%b rtag=%0d blk=%b, want 1 3 1", recover, rec_tag, block);
        end
        for (int k = 4; k <= 6; k++) begin
            tick();
            checks++;
            if (block !== (k <= 5) || recover !== 1'b0) begin
                errors++;
                $display("FAIL nest_block T+%0d: blk=%b rec=%b, want %b 0", k, block, recover, k <= 5);
            end
        end
    endtask

    task automatic test_flush_wrap();
        do_flush();
        push_tag(3);
        resolve(3, 1);
        tick();
        flush = 1;
        tick();
        idle();
        checks++;
        if (block !== 1'b0 || recover !== 1'b0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL flush_drain: blk=%b rec=%b outst=%0d, want 0 0 0", block, recover, outstanding);
        end
        tick();
        checks++;
        if (recover !== 1'b0) begin
            errors++;
            $display("FAIL flush_nopulse: rec=%b, want 0", recover);
        end
        push_tag(20);
        for (int k = 0; k < 10; k++) begin
            resolve(20 + k, 0);
            checks++;
            if (outstanding !== 3'd1) begin
                errors++;
                $display("FAIL wrap_res %0d: outst=%0d, want 1", k, outstanding);
            end
            push_tag(21 + k);
            checks++;
            if (outstanding !== 3'd1) begin
                errors++;
                $display("FAIL wrap_pair %0d: outst=%0d, want 1", k, outstanding);
            end
        end
    endtask

    task automatic test_random();
        int t;
        do_flush();
        for (int c = 0; c < 500; c++) begin
            idle();
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6) begin
                br_valid = 1;
                do t = int'($urandom_range(0, 31)); while (find(t) >= 0);
                br_tag = RW'(t);
            end
            if ($urandom_range(0, 1) == 1) begin
                rs_valid = 1;
                rs_mp    = ($urandom_range(0, 4) == 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    rs_tag = RW'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    rs_tag = RW'($urandom_range(0, 31));
            end
            #1;
            checks++;
            if (take !== m_take() || outstanding !== CW'(mq.size()) || stall !== (mq.size() == MAX_BR)
                || recover !== m_rec || block !== (m_block > 0) || rec_tag !== RW'(m_rtag)) begin
                errors++;
                $display("FAIL random cyc=%0d: take=%b outst=%0d stall=%b rec=%b blk=%b rtag=%0d, want %b %0d %b %b %b %0d",
                         c, take, outstanding, stall, recover, block, rec_tag,
                         m_take(), mq.size(), mq.size() == MAX_BR, m_rec, m_block > 0, m_rtag);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_retire();
        test_mispredict();
        test_race();
        test_nested();
        test_flush_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
